// File: rtl/fm_demod_xor_avg_if.sv
// ============================================================================
// fm_demod_xor_avg_if : sample/control/result bundle for the FM demodulator
// Rev 1.0
// ============================================================================
`default_nettype none

interface fm_demod_xor_avg_if #(
  parameter int DATA_W    = 16,
  parameter int PHASE_W   = 32,
  parameter int MAX_LOG2N = 8
);
  localparam int LEN_W = $clog2(MAX_LOG2N + 1);

  logic               sync_clr;
  logic               in_valid;
  logic [DATA_W-1:0]  modulated;
  logic [PHASE_W-1:0] ctr_ctrl;
  logic [LEN_W-1:0]   log2_len;
  logic               mode;
  logic               out_valid;
  logic [DATA_W-1:0]  demodulated;

  modport master (
    output sync_clr, in_valid, modulated, ctr_ctrl, log2_len, mode,
    input  out_valid, demodulated
  );

  modport slave (
    input  sync_clr, in_valid, modulated, ctr_ctrl, log2_len, mode,
    output out_valid, demodulated
  );
endinterface

`default_nettype wire

// File: rtl/fm_demod_xor_avg.sv
// ============================================================================
// fm_demod_xor_avg : XOR phase detector against a triangle NCO, 2^L block avg
// Rev 1.0
// ============================================================================
`default_nettype none

module fm_demod_xor_avg #(
  parameter int DATA_W    = 16,
  parameter int PHASE_W   = 32,
  parameter int MAX_LOG2N = 8
) (
  input  wire                      clk,
  input  wire                      rst,
  fm_demod_xor_avg_if.slave        bus
);
  localparam int LEN_W = $clog2(MAX_LOG2N + 1);
  localparam int ACC_W = DATA_W + MAX_LOG2N;
  localparam int END_W = MAX_LOG2N + 1;
  localparam logic [LEN_W-1:0]  MAX_L   = LEN_W'(MAX_LOG2N);
  localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

  // Stage 0: NCO reference and detector
  logic [PHASE_W-1:0] phase;
  logic [DATA_W-2:0]  tri_mag;
  logic [DATA_W-1:0]  nco_ref;
  logic [DATA_W-1:0]  xd;
  logic [DATA_W-1:0]  det;

  assign tri_mag = phase[PHASE_W-3 -: DATA_W-1];
  assign nco_ref = {phase[PHASE_W-1], phase[PHASE_W-2] ? ~tri_mag : tri_mag};
  assign xd      = nco_ref ^ bus.modulated;
  assign det     = bus.mode ? (xd[DATA_W-1] ? POS_MAX : NEG_MAX)
                            : {~xd[DATA_W-1], xd[DATA_W-2:0]};

  // Stage 1
  logic              d_valid;
  logic [DATA_W-1:0] d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= '0;
      d_valid <= 1'b0;
      d_q     <= '0;
    end else if (bus.sync_clr) begin
      phase   <= '0;
      d_valid <= 1'b0;
    end else begin
      d_valid <= bus.in_valid;
      if (bus.in_valid) begin
        phase <= phase + bus.ctr_ctrl;
        d_q   <= det;
      end
    end
  end

  // Stage 2: block length is sampled on the first sample of each block
  logic [MAX_LOG2N-1:0]    count;
  logic [LEN_W-1:0]        l_hold;
  logic [LEN_W-1:0]        l_eff_in;
  logic [LEN_W-1:0]        l_use;
  logic [END_W-1:0]        blk_end;
  logic                    last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    ov_q;
  logic [DATA_W-1:0]       demod_q;

  assign l_eff_in = (bus.log2_len > MAX_L) ? MAX_L : bus.log2_len;
  assign l_use    = (count == '0) ? l_eff_in : l_hold;
  assign blk_end  = (END_W'(1) << l_use) - END_W'(1);
  assign last     = ({1'b0, count} == blk_end);
  assign sum      = acc + $signed({{MAX_LOG2N{d_q[DATA_W-1]}}, d_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      l_hold  <= '0;
      acc     <= '0;
      ov_q    <= 1'b0;
      demod_q <= '0;
    end else begin
      ov_q <= 1'b0;
      if (bus.sync_clr) begin
        count <= '0;
        acc   <= '0;
      end else if (d_valid) begin
        if (count == '0) begin
          l_hold <= l_eff_in;
        end
        if (last) begin
          demod_q <= DATA_W'(sum >>> l_use);
          ov_q    <= 1'b1;
          acc     <= '0;
          count   <= '0;
        end else begin
          acc   <= sum;
          count <= count + MAX_LOG2N'(1);
        end
      end
    end
  end

  assign bus.out_valid   = ov_q;
  assign bus.demodulated = demod_q;

endmodule

`default_nettype wire

// File: tb/tb_fm_demod_xor_avg.sv
// ============================================================================
// tb_fm_demod_xor_avg : randomized + directed bench against a sample-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fm_demod_xor_avg;
  localparam int DATA_W    = 16;
  localparam int PHASE_W   = 32;
  localparam int MAX_LOG2N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fm_demod_xor_avg_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .MAX_LOG2N(MAX_LOG2N)) bus ();

  fm_demod_xor_avg #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .MAX_LOG2N(MAX_LOG2N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sample-level model: detector value per accepted sample, block kept as a list
  logic [31:0] m_phase = '0;
  bit          pend_v  = 1'b0;
  int          pend_d  = 0;
  int          blk[$];
  int          blk_l   = 0;
  bit          exp_ov  = 1'b0;
  logic [15:0] exp_dm  = '0;
  logic [15:0] strobes[$];

  function automatic int detect(input logic [31:0] ph, input logic [15:0] m, input logic md);
    int mag, r, x;
    mag = int'((ph >> 15) & 32'h7FFF);
    if (ph[30]) mag = 32767 - mag;
    r = (ph[31] ? 32768 : 0) + mag;
    x = r ^ int'(m);
    if (md) return (x >= 32768) ? 32767 : -32767;
    x = x ^ 32'h8000;
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_reset();
    m_phase = '0;
    pend_v  = 1'b0;
    blk.delete();
    exp_ov  = 1'b0;
    exp_dm  = '0;
  endtask

  task automatic model_edge();
    longint s, n, q;
    int     l;
    if (!rst) begin
      model_reset();
      return;
    end
    exp_ov = 1'b0;
    if (bus.sync_clr) begin
      m_phase = '0;
      pend_v  = 1'b0;
      blk.delete();
      return;
    end
    if (pend_v) begin
      if (blk.size() == 0) begin
        l = int'(bus.log2_len);
        blk_l = (l > MAX_LOG2N) ? MAX_LOG2N : l;
      end
      blk.push_back(pend_d);
      if (blk.size() == (1 << blk_l)) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        n = longint'(1) << blk_l;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        exp_dm = 16'(q);
        exp_ov = 1'b1;
        blk.delete();
      end
    end
    pend_v = bus.in_valid;
    if (bus.in_valid) begin
      pend_d  = detect(m_phase, bus.modulated, bus.mode);
      m_phase = m_phase + bus.ctr_ctrl;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("demodulated", 64'(bus.demodulated), 64'(exp_dm));
    if (bus.out_valid) strobes.push_back(bus.demodulated);
  endtask

  task automatic feed(input logic [15:0] m);
    bus.in_valid  = 1'b1;
    bus.modulated = m;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart();
    bus.sync_clr = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.sync_clr = 1'b0;
    tick();
    strobes.delete();
  endtask

  logic [15:0] t2_exp [4];

  initial begin
    bus.sync_clr  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.modulated = '0;
    bus.ctr_ctrl  = '0;
    bus.log2_len  = '0;
    bus.mode      = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_ov", 64'(bus.out_valid), 64'd0);
    chk("reset_dm", 64'(bus.demodulated), 64'd0);
    rst = 1'b1;
    tick();

    // NCO shape through full-word detector, one output per sample
    t2_exp = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
    bus.ctr_ctrl = 32'h4000_0000;
    bus.mode     = 1'b0;
    bus.log2_len = 4'd0;
    restart();
    for (int i = 0; i < 4; i++) feed(16'h0000);
    idle(2);
    chk("t2_count", 64'(strobes.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < strobes.size()) chk($sformatf("t2_val%0d", i), 64'(strobes[i]), 64'(t2_exp[i]));

    // Sign-only detector
    bus.ctr_ctrl = '0;
    bus.mode     = 1'b1;
    bus.log2_len = 4'd2;
    restart();
    for (int i = 0; i < 4; i++) feed(16'h8000);
    idle(2);
    chk("t3_count_a", 64'(strobes.size()), 64'd1);
    if (strobes.size() > 0) chk("t3_val_a", 64'(strobes[0]), 64'h7FFF);
    strobes.delete();
    feed(16'h8000); feed(16'h8000); feed(16'h0001); feed(16'h0001);
    idle(2);
    chk("t3_count_b", 64'(strobes.size()), 64'd1);
    if (strobes.size() > 0) chk("t3_val_b", 64'(strobes[0]), 64'h0000);

    // Rounding toward minus infinity
    bus.mode     = 1'b0;
    bus.log2_len = 4'd1;
    restart();
    feed(16'h0000);
    feed(16'h0001);
    idle(2);
    chk("t4_count", 64'(strobes.size()), 64'd1);
    if (strobes.size() > 0) chk("t4_val", 64'(strobes[0]), 64'h8000);

    // Stalls and sync_clr
    bus.ctr_ctrl = 32'h0123_4567;
    bus.log2_len = 4'd2;
    restart();
    for (int i = 0; i < 8; i++) begin
      feed(16'($urandom));
      idle(3);
    end
    idle(2);
    chk("t5_gaps", 64'(strobes.size()), 64'd2);
    restart();
    feed(16'($urandom));
    feed(16'($urandom));
    bus.sync_clr  = 1'b1;
    bus.in_valid  = 1'b1;
    bus.modulated = 16'($urandom);
    tick();
    bus.sync_clr  = 1'b0;
    bus.in_valid  = 1'b0;
    idle(3);
    chk("t5_clr_none", 64'(strobes.size()), 64'd0);
    for (int i = 0; i < 4; i++) feed(16'($urandom));
    idle(2);
    chk("t5_clr_clean", 64'(strobes.size()), 64'd1);

    // Length clamp and mid-block length change
    bus.log2_len = 4'd15;
    restart();
    for (int i = 0; i < 255; i++) feed(16'($urandom));
    idle(2);
    chk("t6_255", 64'(strobes.size()), 64'd0);
    feed(16'($urandom));
    idle(2);
    chk("t6_256", 64'(strobes.size()), 64'd1);
    bus.log2_len = 4'd2;
    restart();
    feed(16'($urandom));
    idle(1);
    bus.log2_len = 4'd0;
    feed(16'($urandom));
    feed(16'($urandom));
    idle(2);
    chk("t6_chg_mid", 64'(strobes.size()), 64'd0);
    feed(16'($urandom));
    idle(2);
    chk("t6_chg_end", 64'(strobes.size()), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.sync_clr  = ($urandom % 64) == 0;
      bus.modulated = 16'($urandom);
      bus.ctr_ctrl  = ($urandom % 8 == 0) ? 32'($urandom) : bus.ctr_ctrl;
      bus.mode      = 1'($urandom);
      bus.log2_len  = ($urandom % 50 == 0) ? 4'($urandom_range(9, 15))
                                           : 4'($urandom_range(0, 4));
      tick();
    end
    bus.sync_clr = 1'b0;

    // Asynchronous reset in the middle of a block
    bus.ctr_ctrl = '0;
    bus.mode     = 1'b0;
    bus.log2_len = 4'd3;
    restart();
    for (int i = 0; i < 3; i++) feed(16'h0000);
    rst = 1'b0;
    model_reset();
    #2;
    chk("t1_rst_ov", 64'(bus.out_valid), 64'd0);
    chk("t1_rst_dm", 64'(bus.demodulated), 64'd0);
    idle(2);
    #1;
    rst = 1'b1;
    strobes.delete();
    for (int i = 0; i < 8; i++) feed(16'($urandom));
    idle(2);
    chk("t1_post_count", 64'(strobes.size()), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
